// File: rtl/sobel_window_ctrl_if.sv
// Pixel-stream and 3x3-window handshake bundle between a raster source, the
// window controller and the sobel3x3det datapath.
interface sobel_window_ctrl_if #(
  parameter int PIX_W = 8
);
  logic             start;
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_in;
  logic [PIX_W-1:0] z1, z2, z3, z4, z6, z7, z8, z9;
  logic             win_valid;
  logic             win_ready;
  logic             win_last;
  logic             busy;
  logic             done;

  modport master (
    output start, pix_valid, pix_in, win_ready,
    input  pix_ready, z1, z2, z3, z4, z6, z7, z8, z9,
    input  win_valid, win_last, busy, done
  );

  modport slave (
    input  start, pix_valid, pix_in, win_ready,
    output pix_ready, z1, z2, z3, z4, z6, z7, z8, z9,
    output win_valid, win_last, busy, done
  );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Raster-scan 3x3 window controller: two line buffers plus a column shift
// register feed sobel3x3det one interior-pixel neighbourhood per handshake.
module sobel_window_ctrl #(
  parameter int ROWS  = 436,
  parameter int COLS  = 576,
  parameter int PIX_W = 8
) (
  input logic               i_clk,
  input logic               i_rst_n,
  sobel_window_ctrl_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           r_state;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [PIX_W-1:0] r_lb0 [COLS];
  logic [PIX_W-1:0] r_lb1 [COLS];
  logic [PIX_W-1:0] r_top [3];
  logic [PIX_W-1:0] r_mid [3];
  logic [PIX_W-1:0] r_bot [3];
  logic             r_win_valid;
  logic             r_win_last;
  logic             r_busy;
  logic             r_done;

  logic             w_free;
  logic             w_acc;
  logic             w_last_pix;
  logic             w_interior;
  logic [PIX_W-1:0] w_lb0_rd;
  logic [PIX_W-1:0] w_lb1_rd;

  assign w_free        = ~r_win_valid | bus.win_ready;
  assign bus.pix_ready = (r_state == RUN) & w_free;
  assign w_acc         = bus.pix_valid & bus.pix_ready;
  assign w_last_pix    = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_interior    = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_lb0_rd      = r_lb0[r_col];
  assign w_lb1_rd      = r_lb1[r_col];

  // Stale buffer contents are harmless: they only reach windows never flagged valid.
  always_ff @(posedge i_clk) begin
    if (w_acc) begin
      r_lb1[r_col] <= w_lb0_rd;
      r_lb0[r_col] <= bus.pix_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_top[i] <= '0;
        r_mid[i] <= '0;
        r_bot[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (w_acc) begin
        r_top       <= '{r_top[1], r_top[2], w_lb1_rd};
        r_mid       <= '{r_mid[1], r_mid[2], w_lb0_rd};
        r_bot       <= '{r_bot[1], r_bot[2], bus.pix_in};
        r_win_valid <= w_interior;
        r_win_last  <= w_last_pix;
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else if (r_win_valid && bus.win_ready) begin
        r_win_valid <= 1'b0;
        r_win_last  <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_row       <= '0;
            r_col       <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= RUN;
          end
        end
        RUN: begin
          if (w_acc && w_last_pix) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_free) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.z1        = r_top[0];
  assign bus.z2        = r_top[1];
  assign bus.z3        = r_top[2];
  assign bus.z4        = r_mid[0];
  assign bus.z6        = r_mid[2];
  assign bus.z7        = r_bot[0];
  assign bus.z8        = r_bot[1];
  assign bus.z9        = r_bot[2];
  assign bus.win_valid = r_win_valid;
  assign bus.win_last  = r_win_last;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed and randomized frames for sobel_window_ctrl on a 4x5 image, checked
// against a reference built from the image array and the window/handshake rules.
module tb_sobel_window_ctrl;
  localparam int R = 4;
  localparam int C = 5;
  localparam int W = 8;
  localparam int NPIX = R * C;
  localparam int NWIN = (R - 2) * (C - 2);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sobel_window_ctrl_if #(.PIX_W(W)) bus ();

  sobel_window_ctrl #(.ROWS(R), .COLS(C), .PIX_W(W)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0]  img [R][C];
  logic [63:0]   exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] zs();
    return {bus.z1, bus.z2, bus.z3, bus.z4, bus.z6, bus.z7, bus.z8, bus.z9};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_ready"}, 64'(bus.pix_ready), 64'd0);
    check({tag, "_win_valid"}, 64'(bus.win_valid), 64'd0);
    check({tag, "_win_last"},  64'(bus.win_last),  64'd0);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    check({tag, "_done"},      64'(bus.done),      64'd0);
    check({tag, "_z"},         zs(),               64'd0);
  endtask

  // vmode: 0 pix_valid held high, 1 random. rmode: 0 win_ready high, 1 toggle, 2 random.
  task automatic run_frame(input int vmode, input int rmode, input bit rnd_pix, input int start_at);
    int  n, fin_cyc, nwin;
    bit  pend, pend_n, pv, wr, exp_rdy, finished;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        img[r][c] = rnd_pix ? W'($urandom) : W'(10 * r + c);
    exp_q.delete();
    for (int cr = 1; cr <= R - 2; cr++)
      for (int cc = 1; cc <= C - 2; cc++)
        exp_q.push_back({img[cr-1][cc-1], img[cr-1][cc], img[cr-1][cc+1],
                         img[cr][cc-1],                  img[cr][cc+1],
                         img[cr+1][cc-1], img[cr+1][cc], img[cr+1][cc+1]});

    // Pixels offered while idle must be refused.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.pix_valid = 1'b1;
      bus.pix_in    = W'($urandom);
      bus.win_ready = 1'b1;
      @(negedge clk);
      check("idle_pix_ready", 64'(bus.pix_ready), 64'd0);
      check("idle_busy",      64'(bus.busy),      64'd0);
    end
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;

    n = 0; pend = 0; fin_cyc = -10; nwin = 0; finished = 0;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      pv = (vmode == 0) ? 1'b1 : 1'($urandom_range(1, 0));
      wr = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(cyc % 2) : 1'($urandom_range(1, 0));
      bus.pix_valid = pv;
      bus.pix_in    = (n < NPIX) ? img[n / C][n % C] : W'($urandom);
      bus.win_ready = wr;
      bus.start     = (cyc == start_at);
      @(negedge clk);
      exp_rdy = (n < NPIX) && !(pend && !wr);
      check("win_valid", 64'(bus.win_valid), 64'(pend));
      check("pix_ready", 64'(bus.pix_ready), 64'(exp_rdy));
      check("done",      64'(bus.done),      64'(cyc == fin_cyc + 1));
      check("busy",      64'(bus.busy),      64'(!(fin_cyc >= 0 && cyc > fin_cyc)));
      pend_n = pend;
      if (pend && wr) begin
        if (exp_q.size() > 0) begin
          check("window",   zs(),                 exp_q[0]);
          check("win_last", 64'(bus.win_last),    64'(exp_q.size() == 1));
          void'(exp_q.pop_front());
        end
        nwin++;
        if (exp_q.size() == 0) fin_cyc = cyc;
        pend_n = 1'b0;
      end
      if (pv && exp_rdy) begin
        if ((n / C) >= 2 && (n % C) >= 2) pend_n = 1'b1;
        n++;
      end
      pend = pend_n;
      if (fin_cyc >= 0 && cyc == fin_cyc + 2) finished = 1'b1;
      @(posedge clk); #1;
    end
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    check("frame_finished", 64'(finished), 64'd1);
    check("win_count",      64'(nwin),     64'(NWIN));
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    bus.win_ready = 1'b0;
    #2 rst_n = 1'b0;
    #2 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_frame(0, 0, 1'b0, -1);
    run_frame(0, 1, 1'b0, -1);
    run_frame(0, 0, 1'b0, 7);
    repeat (3) run_frame(1, 2, 1'b1, -1);

    // Abort a live frame with an asynchronous reset once a window is pending.
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 13; k++) begin
      bus.pix_valid = 1'b1;
      bus.pix_in    = W'(10 * (k / C) + k % C);
      bus.win_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;
    bus.win_ready = 1'b0;
    check("pre_reset_win_valid", 64'(bus.win_valid), 64'd1);
    check("pre_reset_busy",      64'(bus.busy),      64'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midframe_reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(0, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Raster-scan window controller that sequences the `sobel3x3det` datapath. It accepts one 8-bit pixel per handshake in row-major order and buffers the two previous image rows. For every interior pixel it presents the 3x3 neighbourhood on `z1..z9` (no `z5`), with a valid/ready handshake. It replaces the software loop that cropped the source image around each centre pixel, so the edge pipeline can run from a streaming source.

## Interface
- `ROWS`, 436, image height in pixels (>= 3)
- `COLS`, 576, image width in pixels (>= 3)
- `PIX_W`, 8, pixel width in bits
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: single-cycle frame start request, honoured only in IDLE
- `pix_valid` in 1: source pixel valid
- `pix_in` in PIX_W: source pixel, raster order
- `pix_ready` out 1: controller accepts `pix_in` this cycle
- `z1`,`z2`,`z3`,`z4`,`z6`,`z7`,`z8`,`z9` out PIX_W each: window to `sobel3x3det`
- `win_valid` out 1: window on `z*` is valid
- `win_ready` in 1: downstream consumes window (captures `z_out`)
- `win_last` out 1: qualifies the final window of the frame
- `busy` out 1: high in RUN and DRAIN
- `done` out 1: one-cycle pulse at end of frame

## Operation
- The pixel accept event is `acc = pix_valid & pix_ready`.
- `pix_ready = (state==RUN) & (~win_valid | win_ready)`.
- Counters:
  - `col` runs 0..COLS-1 and `row` runs 0..ROWS-1, both advanced on `acc`.
  - When `col` wraps to 0, `row` increments.
  - Counter widths are `$clog2(ROWS)` and `$clog2(COLS)`.
- Line buffers: `lb0` holds row r-1 and `lb1` holds row r-2, each COLS x PIX_W. On `acc` at column c:
  - Read `lb0[c]` and `lb1[c]`.
  - Write `lb1[c] <= lb0[c]` and `lb0[c] <= pix_in`.
  - Buffers are not cleared by reset or start, because invalid contents are never flagged valid.
- Window is a 3x3 shift register, one column per `acc`. The new right column is {top=`lb1[c]`, mid=`lb0[c]`, bot=`pix_in`}.
- Output mapping:
  - `z1,z2,z3` = top row, left to right.
  - `z4,z6` = mid row, left and right.
  - `z7,z8,z9` = bottom row, left to right.
- Window valid rule: an `acc` at (r,c) with r>=2 and c>=2 sets `win_valid` next cycle.
  - That window's centre is pixel (r-1,c-1).
  - Other accepts clear `win_valid` unless it is still held; a held window is cleared by `win_ready`.
- `win_last` is asserted with the window produced by `acc` at (ROWS-1,COLS-1).
- Windows per frame: (ROWS-2)*(COLS-2), in raster order of centre pixel.
- FSM:
  - IDLE: on `start`, clear `row`, `col`, `win_valid`; go to RUN.
  - RUN: accept pixels. On `acc` at (ROWS-1,COLS-1), go to DRAIN.
  - DRAIN: `pix_ready=0`. When `~win_valid | win_ready`, go to DONE.
  - DONE: `done=1` for one cycle; go to IDLE.
- Boundary rules:
  - `start` outside IDLE is ignored.
  - `pix_valid` outside RUN is not accepted.
  - Row wrap: the first two accepts of each row shift stale columns into the window, but `win_valid` stays low.
  - Reset mid-frame returns to IDLE immediately. Any partial window is discarded and the next frame needs `start`.

## Timing
- Reset values: state=IDLE; `pix_ready`, `win_valid`, `win_last`, `busy`, `done` = 0; `z*` = 0; `row`, `col` = 0.
- Latency: 1 cycle from `acc` to `win_valid`/`z*` update.
- `z*`, `win_valid` and `win_last` are stable while `win_valid & ~win_ready`.
- Throughput: one pixel and one window per cycle when `pix_valid` and `win_ready` are held high.
- `sobel3x3det` is combinational; downstream samples `z_out` in the same cycle as `win_valid & win_ready`.
- `done` is asserted 1 cycle after the last window handshake, or after entering DRAIN with no pending window.

## Test plan
- ROWS=4, COLS=5, pixel = 10*r+c, `pix_valid` and `win_ready` held high.
  - The first `win_valid` follows the `acc` of (2,2) and carries `z1..z9` = 0,1,2,10,12,20,21,22.
  - Exactly 6 windows are produced, the last carrying `z9`=34 with `win_last`=1.
- Same image with `win_ready` toggling 0/1 every cycle.
  - `pix_ready` is low whenever a window is held.
  - Window values are unchanged while stalled.
  - The same 6 windows arrive in order with no loss or duplicate.
- Pixels at row wrap (accepts of (3,0) and (3,1)) produce no `win_valid`.
  - The next valid window is centre (2,1): `z1..z9` = 10,11,12,20,22,30,31,32.
- `start` pulsed during RUN and `pix_valid` high in IDLE: both ignored.
  - `pix_ready`=0 in IDLE.
  - The frame completes normally and `done` pulses exactly once.
- `reset` driven low after 8 accepts: all outputs go to 0 asynchronously.
  - After release, `start` and a full frame give the same 6 windows as the first test.
- Full-size 436x576 frame from `src.txt`, compared against a software Sobel golden output.
  - 434*574 windows.
  - `busy` low after `done`.
